uart_port: RTL and testbench

//  Byte-level UART peripheral that responds to the CPU-side UART I/O strobes
//  of the j1a top (uart0_wr / uart0_rd / uart_w / uart0_valid / uart0_data).

---
 rtl/uart_port.sv | 259 +++++++++++++++++++++++++
 tb/tb_uart_port.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_port.sv
// uart_port: byte-wide 8N1 UART with TX and RX FIFOs on the j1a I/O strobes.
// The RX head is shown ahead; the overrun and framing flags are sticky.
`timescale 1ns/1ps
module uart_port #(
  parameter logic [15:0] CLKS_PER_BIT = 16'd104,
  parameter int unsigned FIFO_LOG2    = 3
) (
  input  logic       clk,
  input  logic       resetq,
  input  logic       uart0_wr,
  input  logic [7:0] uart_w,
  input  logic       uart0_rd,
  output logic       uart0_valid,
  output logic [7:0] uart0_data,
  output logic       tx_full,
  output logic       tx_idle,
  output logic       rx_overrun,
  output logic       rx_frame_err,
  output logic       uart_tx,
  input  logic       uart_rx
);

  localparam int DEPTH = 1 << FIFO_LOG2;
  localparam int PW    = FIFO_LOG2 + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } st_e;

  // TX side
  logic [7:0]    tx_mem_q [DEPTH];
  logic [PW-1:0] tx_wp_q, tx_wp_d;
  logic [PW-1:0] tx_rp_q, tx_rp_d;
  logic          tx_empty, tx_full_w;
  logic          tx_push, tx_pop;
  st_e           tx_st_q, tx_st_d;
  logic [15:0]   tx_cnt_q, tx_cnt_d;
  logic [2:0]    tx_bit_q, tx_bit_d;
  logic [7:0]    tx_sh_q, tx_sh_d;
  logic          tx_o_q, tx_o_d;

  // RX side
  logic          rx_s1_q, rx_s2_q;
  logic [7:0]    rx_mem_q [DEPTH];
  logic [PW-1:0] rx_wp_q, rx_wp_d;
  logic [PW-1:0] rx_rp_q, rx_rp_d;
  logic          rx_empty, rx_full;
  logic          rx_push, rx_wr, rx_pop;
  st_e           rx_st_q, rx_st_d;
  logic [15:0]   rx_cnt_q, rx_cnt_d;
  logic [2:0]    rx_bit_q, rx_bit_d;
  logic [7:0]    rx_sh_q, rx_sh_d;
  logic          rx_arm_q, rx_arm_d;
  logic          ovr_q, ovr_d;
  logic          ferr_q, ferr_d;
  logic          ferr_set;

  assign tx_empty  = (tx_wp_q == tx_rp_q);
  assign tx_full_w = (tx_wp_q[PW-1] != tx_rp_q[PW-1]) &&
                     (tx_wp_q[PW-2:0] == tx_rp_q[PW-2:0]);
  assign tx_push   = uart0_wr && !tx_full_w;
  assign tx_wp_d   = tx_wp_q + {{(PW-1){1'b0}}, tx_push};
  assign tx_rp_d   = tx_rp_q + {{(PW-1){1'b0}}, tx_pop};

  assign rx_empty = (rx_wp_q == rx_rp_q);
  assign rx_full  = (rx_wp_q[PW-1] != rx_rp_q[PW-1]) &&
                    (rx_wp_q[PW-2:0] == rx_rp_q[PW-2:0]);
  assign rx_pop   = uart0_rd && !rx_empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts
  assign rx_wr    = rx_push && (!rx_full || rx_pop);
  assign rx_wp_d  = rx_wp_q + {{(PW-1){1'b0}}, rx_wr};
  assign rx_rp_d  = rx_rp_q + {{(PW-1){1'b0}}, rx_pop};

  // FIFO storage, no reset needed since empty FIFOs mask their contents
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem_q[tx_wp_q[PW-2:0]] <= uart_w;
    if (rx_wr)   rx_mem_q[rx_wp_q[PW-2:0]] <= rx_sh_q;
  end

  // State registers for both directions
  always_ff @(posedge clk) begin
    if (!resetq) begin
      tx_wp_q  <= '0;
      tx_rp_q  <= '0;
      tx_st_q  <= S_IDLE;
      tx_cnt_q <= '0;
      tx_bit_q <= '0;
      tx_sh_q  <= '0;
      tx_o_q   <= 1'b1;
      rx_s1_q  <= 1'b1;
      rx_s2_q  <= 1'b1;
      rx_wp_q  <= '0;
      rx_rp_q  <= '0;
      rx_st_q  <= S_IDLE;
      rx_cnt_q <= '0;
      rx_bit_q <= '0;
      rx_sh_q  <= '0;
      rx_arm_q <= 1'b0;
      ovr_q    <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      tx_wp_q  <= tx_wp_d;
      tx_rp_q  <= tx_rp_d;
      tx_st_q  <= tx_st_d;
      tx_cnt_q <= tx_cnt_d;
      tx_bit_q <= tx_bit_d;
      tx_sh_q  <= tx_sh_d;
      tx_o_q   <= tx_o_d;
      rx_s1_q  <= uart_rx;
      rx_s2_q  <= rx_s1_q;
      rx_wp_q  <= rx_wp_d;
      rx_rp_q  <= rx_rp_d;
      rx_st_q  <= rx_st_d;
      rx_cnt_q <= rx_cnt_d;
      rx_bit_q <= rx_bit_d;
      rx_sh_q  <= rx_sh_d;
      rx_arm_q <= rx_arm_d;
      ovr_q    <= ovr_d;
      ferr_q   <= ferr_d;
    end
  end

  // TX next state: line level is computed one cycle ahead so uart_tx is a flop
  always_comb begin
    tx_st_d  = tx_st_q;
    tx_cnt_d = tx_cnt_q;
    tx_bit_d = tx_bit_q;
    tx_sh_d  = tx_sh_q;
    tx_o_d   = tx_o_q;
    tx_pop   = 1'b0;
    unique case (tx_st_q)
      S_IDLE: begin
        tx_o_d = 1'b1;
        if (!tx_empty) begin
          tx_pop   = 1'b1;
          tx_sh_d  = tx_mem_q[tx_rp_q[PW-2:0]];
          tx_cnt_d = CLKS_PER_BIT - 16'd1;
          tx_o_d   = 1'b0;
          tx_st_d  = S_START;
        end
      end
      S_START: begin
        if (tx_cnt_q == 16'd0) begin
          tx_cnt_d = CLKS_PER_BIT - 16'd1;
          tx_bit_d = 3'd0;
          tx_o_d   = tx_sh_q[0];
          tx_st_d  = S_DATA;
        end else begin
          tx_cnt_d = tx_cnt_q - 16'd1;
        end
      end
      S_DATA: begin
        if (tx_cnt_q == 16'd0) begin
          tx_cnt_d = CLKS_PER_BIT - 16'd1;
          if (tx_bit_q == 3'd7) begin
            tx_o_d  = 1'b1;
            tx_st_d = S_STOP;
          end else begin
            tx_bit_d = tx_bit_q + 3'd1;
            tx_sh_d  = {1'b0, tx_sh_q[7:1]};
            tx_o_d   = tx_sh_q[1];
          end
        end else begin
          tx_cnt_d = tx_cnt_q - 16'd1;
        end
      end
      S_STOP: begin
        if (tx_cnt_q == 16'd0) begin
          tx_st_d = S_IDLE;
        end else begin
          tx_cnt_d = tx_cnt_q - 16'd1;
        end
      end
    endcase
  end

  // RX next state: re-arming needs a high line so a break yields one frame
  always_comb begin
    rx_st_d  = rx_st_q;
    rx_cnt_d = rx_cnt_q;
    rx_bit_d = rx_bit_q;
    rx_sh_d  = rx_sh_q;
    rx_arm_d = rx_arm_q;
    rx_push  = 1'b0;
    ferr_set = 1'b0;
    unique case (rx_st_q)
      S_IDLE: begin
        if (rx_s2_q) rx_arm_d = 1'b1;
        if (rx_arm_q && !rx_s2_q) begin
          rx_cnt_d = CLKS_PER_BIT >> 1;
          rx_st_d  = S_START;
        end
      end
      S_START: begin
        if (rx_cnt_q == 16'd0) begin
          if (!rx_s2_q) begin
            rx_cnt_d = CLKS_PER_BIT - 16'd1;
            rx_bit_d = 3'd0;
            rx_st_d  = S_DATA;
          end else begin
            rx_st_d = S_IDLE;
          end
        end else begin
          rx_cnt_d = rx_cnt_q - 16'd1;
        end
      end
      S_DATA: begin
        if (rx_cnt_q == 16'd0) begin
          rx_sh_d  = {rx_s2_q, rx_sh_q[7:1]};
          rx_cnt_d = CLKS_PER_BIT - 16'd1;
          if (rx_bit_q == 3'd7) begin
            rx_st_d = S_STOP;
          end else begin
            rx_bit_d = rx_bit_q + 3'd1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q - 16'd1;
        end
      end
      S_STOP: begin
        if (rx_cnt_q == 16'd0) begin
          rx_st_d  = S_IDLE;
          rx_arm_d = rx_s2_q;
          if (rx_s2_q) rx_push = 1'b1;
          else         ferr_set = 1'b1;
        end else begin
          rx_cnt_d = rx_cnt_q - 16'd1;
        end
      end
    endcase
  end

  // Sticky flags: a read clears them, a new event in the same cycle wins
  always_comb begin
    ovr_d  = ovr_q;
    ferr_d = ferr_q;
    if (uart0_rd) begin
      ovr_d  = 1'b0;
      ferr_d = 1'b0;
    end
    if (rx_push && !rx_wr) ovr_d  = 1'b1;
    if (ferr_set)          ferr_d = 1'b1;
  end

  // Outputs, all derived from registered state
  always_comb begin
    tx_full      = tx_full_w;
    tx_idle      = tx_empty && (tx_st_q == S_IDLE);
    uart_tx      = tx_o_q;
    uart0_valid  = !rx_empty;
    uart0_data   = rx_empty ? 8'h00 : rx_mem_q[rx_rp_q[PW-2:0]];
    rx_overrun   = ovr_q;
    rx_frame_err = ferr_q;
  end

endmodule

// File: tb/tb_uart_port.sv
// tb_uart_port: table vectors plus scoreboards for the TX and RX paths.
// Runs with 4 clocks per bit and 8-entry FIFOs.
`timescale 1ns/1ps
module tb_uart_port;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       resetq = 1'b0;
  logic       uart0_wr = 1'b0;
  logic [7:0] uart_w = 8'h00;
  logic       uart0_rd = 1'b0;
  logic       uart_rx = 1'b1;
  logic       uart0_valid;
  logic [7:0] uart0_data;
  logic       tx_full, tx_idle, rx_overrun, rx_frame_err, uart_tx;

  int checks = 0;
  int errors = 0;
  int tx_frames = 0;
  bit mon_en = 1'b0;
  logic [7:0] txq[$];
  logic [7:0] rxq[$];
  logic [7:0] mon_b;

  typedef struct {
    logic [7:0] d;
    logic       stop;
    logic       glitch;
    logic       exp_valid;
    logic [7:0] exp_data;
    logic       exp_ferr;
  } rxv_t;

  rxv_t tv[6];

  uart_port #(
    .CLKS_PER_BIT(16'd4),
    .FIFO_LOG2(3)
  ) dut (
    .clk(clk),
    .resetq(resetq),
    .uart0_wr(uart0_wr),
    .uart_w(uart_w),
    .uart0_rd(uart0_rd),
    .uart0_valid(uart0_valid),
    .uart0_data(uart0_data),
    .tx_full(tx_full),
    .tx_idle(tx_idle),
    .rx_overrun(rx_overrun),
    .rx_frame_err(rx_frame_err),
    .uart_tx(uart_tx),
    .uart_rx(uart_rx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    logic [9:0] f;
    f = {stop, d, 1'b0};
    for (int i = 0; i < 10; i++) begin
      uart_rx = f[i];
      repeat (CPB) @(negedge clk);
    end
    uart_rx = 1'b1;
    repeat (3 * CPB) @(negedge clk);
  endtask

  task automatic do_read(input string nm);
    chk({nm, "_valid"}, 32'(uart0_valid), 32'd1);
    if (rxq.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s_sb got=%0h want=empty", nm, uart0_data);
    end else begin
      chk({nm, "_data"}, 32'(uart0_data), 32'(rxq.pop_front()));
    end
    uart0_rd = 1'b1;
    @(negedge clk);
    uart0_rd = 1'b0;
  endtask

  // TX monitor: decode frames at mid-bit and score them against txq
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en && resetq && uart_tx === 1'b0) begin
        repeat (CPB / 2) @(negedge clk);
        chk("tx_start", 32'(uart_tx), 32'd0);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          mon_b[i] = uart_tx;
        end
        repeat (CPB) @(negedge clk);
        chk("tx_stop", 32'(uart_tx), 32'd1);
        if (txq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL tx_unexpected got=%0h want=none", mon_b);
        end else begin
          chk("tx_byte", 32'(mon_b), 32'(txq.pop_front()));
        end
        tx_frames++;
      end
    end
  end

  initial begin
    #200us;
    $display("FAIL timeout got=running want=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [9:0] pat;
    int n;

    tv[0] = '{8'h3C, 1'b1, 1'b0, 1'b1, 8'h3C, 1'b0};
    tv[1] = '{8'h00, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0};
    tv[2] = '{8'hFF, 1'b1, 1'b0, 1'b1, 8'hFF, 1'b0};
    tv[3] = '{8'h81, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1};
    tv[4] = '{8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0};
    tv[5] = '{8'hA5, 1'b1, 1'b0, 1'b1, 8'hA5, 1'b0};

    resetq = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_tx", 32'(uart_tx), 32'd1);
    chk("rst_valid", 32'(uart0_valid), 32'd0);
    chk("rst_data", 32'(uart0_data), 32'd0);
    chk("rst_full", 32'(tx_full), 32'd0);
    chk("rst_idle", 32'(tx_idle), 32'd1);
    chk("rst_ovr", 32'(rx_overrun), 32'd0);
    chk("rst_ferr", 32'(rx_frame_err), 32'd0);
    resetq = 1'b1;

    // Reset in the middle of a frame of zeros
    uart_w = 8'h00;
    uart0_wr = 1'b1;
    @(negedge clk);
    uart0_wr = 1'b0;
    repeat (10) @(negedge clk);
    chk("midtx_low", 32'(uart_tx), 32'd0);
    chk("midtx_busy", 32'(tx_idle), 32'd0);
    resetq = 1'b0;
    @(negedge clk);
    chk("midrst_tx", 32'(uart_tx), 32'd1);
    chk("midrst_idle", 32'(tx_idle), 32'd1);
    chk("midrst_valid", 32'(uart0_valid), 32'd0);
    @(negedge clk);
    resetq = 1'b1;
    repeat (3) @(negedge clk);
    chk("postrst_idle", 32'(tx_idle), 32'd1);
    chk("postrst_tx", 32'(uart_tx), 32'd1);

    // Exact bit timing of one frame
    mon_en = 1'b1;
    pat = {1'b1, 8'hA5, 1'b0};
    txq.push_back(8'hA5);
    uart_w = 8'hA5;
    uart0_wr = 1'b1;
    @(negedge clk);
    uart0_wr = 1'b0;
    chk("a5_busy", 32'(tx_idle), 32'd0);
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      chk("a5_bit", 32'(uart_tx), 32'(pat[k / 4]));
    end
    chk("a5_notidle", 32'(tx_idle), 32'd0);
    @(negedge clk);
    chk("a5_idle", 32'(tx_idle), 32'd1);

    // Ten writes in a row: one goes to the shifter, eight fill the FIFO
    tx_frames = 0;
    for (int i = 0; i < 10; i++) begin
      if (i == 8) chk("txf_notfull", 32'(tx_full), 32'd0);
      if (i == 9) chk("txf_full", 32'(tx_full), 32'd1);
      uart_w = 8'h10 + 8'(i);
      uart0_wr = 1'b1;
      if (i < 9) txq.push_back(8'h10 + 8'(i));
      @(negedge clk);
    end
    uart0_wr = 1'b0;
    chk("txf_still_full", 32'(tx_full), 32'd1);
    n = 0;
    while (!tx_idle && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("txf_drained", 32'(tx_idle), 32'd1);
    repeat (2) @(negedge clk);
    chk("txf_frames", 32'(tx_frames), 32'd9);
    chk("txf_sb_empty", 32'(txq.size()), 32'd0);

    // Receive vectors
    for (int v = 0; v < 6; v++) begin
      if (tv[v].glitch) begin
        uart_rx = 1'b0;
        @(negedge clk);
        uart_rx = 1'b1;
        repeat (12 * CPB) @(negedge clk);
      end else begin
        if (tv[v].stop) rxq.push_back(tv[v].d);
        send_frame(tv[v].d, tv[v].stop);
      end
      chk("rxv_valid", 32'(uart0_valid), 32'(tv[v].exp_valid));
      chk("rxv_data", 32'(uart0_data), 32'(tv[v].exp_data));
      chk("rxv_ferr", 32'(rx_frame_err), 32'(tv[v].exp_ferr));
      chk("rxv_ovr", 32'(rx_overrun), 32'd0);
      if (tv[v].exp_valid) begin
        do_read("rxv_rd");
        chk("rxv_empty", 32'(uart0_valid), 32'd0);
      end
      if (tv[v].exp_ferr) begin
        uart0_rd = 1'b1;
        @(negedge clk);
        uart0_rd = 1'b0;
        chk("rxv_ferr_clr", 32'(rx_frame_err), 32'd0);
      end
    end

    // Overrun, then a framing error, then one read clears both
    for (int i = 0; i < 9; i++) begin
      if (i < 8) rxq.push_back(8'h40 + 8'(i));
      send_frame(8'h40 + 8'(i), 1'b1);
    end
    chk("ovr_valid", 32'(uart0_valid), 32'd1);
    chk("ovr_flag", 32'(rx_overrun), 32'd1);
    chk("ovr_ferr", 32'(rx_frame_err), 32'd0);
    chk("ovr_head", 32'(uart0_data), 32'h40);
    send_frame(8'hEE, 1'b0);
    chk("fe_flag", 32'(rx_frame_err), 32'd1);
    chk("fe_ovr", 32'(rx_overrun), 32'd1);
    chk("fe_head", 32'(uart0_data), 32'h40);
    do_read("ovr_rd");
    chk("clr_ovr", 32'(rx_overrun), 32'd0);
    chk("clr_ferr", 32'(rx_frame_err), 32'd0);
    chk("clr_next", 32'(uart0_data), 32'h41);
    n = 0;
    while (rxq.size() > 0 && n < 16) begin
      do_read("drain_rd");
      n++;
    end
    chk("drain_valid", 32'(uart0_valid), 32'd0);
    chk("drain_data", 32'(uart0_data), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
